// File: rtl/alu_rs_scheduler.sv
// Reservation station and issue scheduler in front of the single-cycle ALU.
// Holds renamed ALU micro-ops until both operands are valid. Operands wake
// from the CDB and from this block's own tagged result. One ready entry per
// cycle is selected (lowest index wins) and driven to the ALU. The ALU result
// is tagged with the destination ROB index and broadcast.
//
// Ports:
//   clk_in, rst_in (async, active-low), rdy_in (low freezes), clear (flush)
//   issue_*      : micro-op from the dispatcher; full back-pressures it
//   cdb_*        : external wakeup broadcast
//   alu_cal/a/b/op       : ALU start and operands (registered)
//   alu_cal_out/result   : ALU result, one cycle after alu_cal
//   out_valid/tag/value  : tagged ALU result broadcast (registered)
module alu_rs_scheduler #(
   parameter  int unsigned ROB_WIDTH = 4,
   parameter  int unsigned RS_WIDTH  = 3,
   parameter  int unsigned RS_SIZE   = 8,
   localparam int unsigned DATA_W    = 32,
   localparam int unsigned OP_W      = 4
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 rdy_in,
   input  logic                 clear,
   input  logic                 issue_valid,
   input  logic [OP_W-1:0]      issue_op,
   input  logic [DATA_W-1:0]    issue_vj,
   input  logic                 issue_qj_valid,
   input  logic [ROB_WIDTH-1:0] issue_qj,
   input  logic [DATA_W-1:0]    issue_vk,
   input  logic                 issue_qk_valid,
   input  logic [ROB_WIDTH-1:0] issue_qk,
   input  logic [ROB_WIDTH-1:0] issue_dest,
   output logic                 full,
   input  logic                 cdb_valid,
   input  logic [ROB_WIDTH-1:0] cdb_tag,
   input  logic [DATA_W-1:0]    cdb_value,
   output logic                 alu_cal,
   output logic [DATA_W-1:0]    alu_a,
   output logic [DATA_W-1:0]    alu_b,
   output logic [OP_W-1:0]      alu_op,
   input  logic                 alu_cal_out,
   input  logic [DATA_W-1:0]    alu_result,
   output logic                 out_valid,
   output logic [ROB_WIDTH-1:0] out_tag,
   output logic [DATA_W-1:0]    out_value
);

   typedef struct packed {
      logic                 valid;
      logic [OP_W-1:0]      op;
      logic [DATA_W-1:0]    vj;
      logic                 qj_valid;
      logic [ROB_WIDTH-1:0] qj;
      logic [DATA_W-1:0]    vk;
      logic                 qk_valid;
      logic [ROB_WIDTH-1:0] qk;
      logic [ROB_WIDTH-1:0] dest;
   } entry_t;

   entry_t ent_q [RS_SIZE];
   entry_t ent_d [RS_SIZE];

   logic                 sel_found;
   logic [RS_WIDTH-1:0]  sel_idx;
   logic                 alloc_found;
   logic [RS_WIDTH-1:0]  alloc_idx;

   // Selected op tag while alu_cal is high, then while the ALU result is pending.
   logic                 inflight_valid;
   logic [ROB_WIDTH-1:0] inflight_tag;
   logic                 exec_valid;
   logic [ROB_WIDTH-1:0] exec_tag;

   // Operand wakeup: returns {q_valid, value}; the CDB beats our own result on a tag tie.
   function automatic logic [DATA_W:0] wake(
      input logic                 qv,
      input logic [ROB_WIDTH-1:0] q,
      input logic [DATA_W-1:0]    v,
      input logic                 cv,
      input logic [ROB_WIDTH-1:0] ct,
      input logic [DATA_W-1:0]    cval,
      input logic                 ov,
      input logic [ROB_WIDTH-1:0] ot,
      input logic [DATA_W-1:0]    oval
   );
      logic [DATA_W:0] r;
      r = {qv, v};
      if (qv && ov && (q == ot)) r = {1'b0, oval};
      if (qv && cv && (q == ct)) r = {1'b0, cval};
      return r;
   endfunction

   // Priority scan: lowest ready entry to select, lowest free entry to allocate.
   always_comb begin
      sel_found   = 1'b0;
      sel_idx     = '0;
      alloc_found = 1'b0;
      alloc_idx   = '0;
      full        = 1'b1;
      for (int i = int'(RS_SIZE) - 1; i >= 0; i--) begin
         if (ent_q[i].valid && !ent_q[i].qj_valid && !ent_q[i].qk_valid) begin
            sel_found = 1'b1;
            sel_idx   = RS_WIDTH'(i);
         end
         if (!ent_q[i].valid) begin
            alloc_found = 1'b1;
            alloc_idx   = RS_WIDTH'(i);
            full        = 1'b0;
         end
      end
   end

   // Entry next state: wakeup, release of the selected slot, allocation, flush.
   always_comb begin
      ent_d = ent_q;
      for (int i = 0; i < int'(RS_SIZE); i++) begin
         {ent_d[i].qj_valid, ent_d[i].vj} = wake(ent_q[i].qj_valid, ent_q[i].qj, ent_q[i].vj,
                                                 cdb_valid, cdb_tag, cdb_value,
                                                 out_valid, out_tag, out_value);
         {ent_d[i].qk_valid, ent_d[i].vk} = wake(ent_q[i].qk_valid, ent_q[i].qk, ent_q[i].vk,
                                                 cdb_valid, cdb_tag, cdb_value,
                                                 out_valid, out_tag, out_value);
      end
      if (sel_found) ent_d[sel_idx].valid = 1'b0;
      // alloc_idx comes from the pre-edge state, so a slot freed by select is never reused here.
      if (issue_valid && alloc_found) begin
         ent_d[alloc_idx].valid = 1'b1;
         ent_d[alloc_idx].op    = issue_op;
         ent_d[alloc_idx].qj    = issue_qj;
         ent_d[alloc_idx].qk    = issue_qk;
         ent_d[alloc_idx].dest  = issue_dest;
         {ent_d[alloc_idx].qj_valid, ent_d[alloc_idx].vj} =
            wake(issue_qj_valid, issue_qj, issue_vj, cdb_valid, cdb_tag, cdb_value,
                 out_valid, out_tag, out_value);
         {ent_d[alloc_idx].qk_valid, ent_d[alloc_idx].vk} =
            wake(issue_qk_valid, issue_qk, issue_vk, cdb_valid, cdb_tag, cdb_value,
                 out_valid, out_tag, out_value);
      end
      if (clear) begin
         for (int i = 0; i < int'(RS_SIZE); i++) ent_d[i].valid = 1'b0;
      end
   end

   // State, ALU drive and result broadcast registers.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         ent_q          <= '{default: '0};
         alu_cal        <= 1'b0;
         alu_a          <= '0;
         alu_b          <= '0;
         alu_op         <= '0;
         inflight_valid <= 1'b0;
         inflight_tag   <= '0;
         exec_valid     <= 1'b0;
         exec_tag       <= '0;
         out_valid      <= 1'b0;
         out_tag        <= '0;
         out_value      <= '0;
      end else if (!rdy_in) begin
         alu_cal   <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         ent_q     <= ent_d;
         out_tag   <= exec_tag;
         out_value <= alu_result;
         if (clear) begin
            alu_cal        <= 1'b0;
            inflight_valid <= 1'b0;
            exec_valid     <= 1'b0;
            out_valid      <= 1'b0;
         end else begin
            alu_cal        <= sel_found;
            inflight_valid <= sel_found;
            if (sel_found) begin
               alu_a        <= ent_q[sel_idx].vj;
               alu_b        <= ent_q[sel_idx].vk;
               alu_op       <= ent_q[sel_idx].op;
               inflight_tag <= ent_q[sel_idx].dest;
            end
            exec_valid <= inflight_valid;
            exec_tag   <= inflight_tag;
            out_valid  <= alu_cal_out & exec_valid;
         end
      end
   end

endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Self-checking bench for alu_rs_scheduler: directed scenarios followed by a
// randomized phase, all compared every cycle against a queue-based model.
module tb_alu_rs_scheduler;

   localparam int RS = 8;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        rdy_in;
   logic        clear;
   logic        issue_valid;
   logic [3:0]  issue_op;
   logic [31:0] issue_vj;
   logic        issue_qj_valid;
   logic [3:0]  issue_qj;
   logic [31:0] issue_vk;
   logic        issue_qk_valid;
   logic [3:0]  issue_qk;
   logic [3:0]  issue_dest;
   logic        full;
   logic        cdb_valid;
   logic [3:0]  cdb_tag;
   logic [31:0] cdb_value;
   logic        alu_cal;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [3:0]  alu_op;
   logic        alu_cal_out;
   logic [31:0] alu_result;
   logic        out_valid;
   logic [3:0]  out_tag;
   logic [31:0] out_value;

   int checks = 0;
   int errors = 0;

   alu_rs_scheduler dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
      .issue_valid(issue_valid), .issue_op(issue_op), .issue_vj(issue_vj),
      .issue_qj_valid(issue_qj_valid), .issue_qj(issue_qj), .issue_vk(issue_vk),
      .issue_qk_valid(issue_qk_valid), .issue_qk(issue_qk), .issue_dest(issue_dest),
      .full(full), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
      .alu_cal(alu_cal), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_cal_out(alu_cal_out), .alu_result(alu_result),
      .out_valid(out_valid), .out_tag(out_tag), .out_value(out_value)
   );

   always #5 clk_in = ~clk_in;

   function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      case (op)
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return a ^ b;
         4'd5:    return a << b[4:0];
         default: return a + b;
      endcase
   endfunction

   // Stand-in single-cycle ALU: result one cycle after cal.
   always @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         alu_cal_out <= 1'b0;
         alu_result  <= 32'd0;
      end else begin
         alu_cal_out <= alu_cal;
         alu_result  <= alu_fn(alu_op, alu_a, alu_b);
      end
   end

   // ---------------- reference model ----------------
   typedef struct {
      logic        valid;
      logic [3:0]  op;
      logic [31:0] vj;
      logic        qjv;
      logic [3:0]  qj;
      logic [31:0] vk;
      logic        qkv;
      logic [3:0]  qk;
      logic [3:0]  dest;
   } ment_t;

   typedef struct {
      logic [3:0]  tag;
      logic [31:0] val;
      int          due;
   } pend_t;

   ment_t       m [RS];
   pend_t       pq [$];
   int          cyc = 0;
   logic        m_full, m_alu_cal, m_out_valid;
   logic [31:0] m_alu_a, m_alu_b, m_out_value;
   logic [3:0]  m_alu_op, m_out_tag;

   task automatic model_reset();
      for (int i = 0; i < RS; i++) m[i] = '{default: '0};
      pq.delete();
      m_full = 1'b0; m_alu_cal = 1'b0; m_out_valid = 1'b0;
      m_alu_a = 32'd0; m_alu_b = 32'd0; m_alu_op = 4'd0;
      m_out_tag = 4'd0; m_out_value = 32'd0;
   endtask

   task automatic wake_op(inout logic qv, input logic [3:0] q, inout logic [31:0] v);
      if (qv) begin
         if (cdb_valid && cdb_tag == q) begin
            v = cdb_value; qv = 1'b0;
         end else if (m_out_valid && m_out_tag == q) begin
            v = m_out_value; qv = 1'b0;
         end
      end
   endtask

   // Advance the model by one clock edge using the inputs present before the edge.
   task automatic model_step();
      ment_t nm [RS];
      int sel, al;
      nm = m;
      if (!rdy_in) begin
         m_alu_cal = 1'b0; m_out_valid = 1'b0; pq.delete();
      end else if (clear) begin
         for (int i = 0; i < RS; i++) nm[i].valid = 1'b0;
         m_alu_cal = 1'b0; m_out_valid = 1'b0; pq.delete();
      end else begin
         sel = -1; al = -1;
         for (int i = 0; i < RS; i++) begin
            if (sel < 0 && m[i].valid && !m[i].qjv && !m[i].qkv) sel = i;
            if (al < 0 && !m[i].valid) al = i;
         end
         for (int i = 0; i < RS; i++) begin
            if (nm[i].valid) begin
               wake_op(nm[i].qjv, nm[i].qj, nm[i].vj);
               wake_op(nm[i].qkv, nm[i].qk, nm[i].vk);
            end
         end
         if (sel >= 0) begin
            m_alu_cal = 1'b1;
            m_alu_a = m[sel].vj; m_alu_b = m[sel].vk; m_alu_op = m[sel].op;
            pq.push_back('{m[sel].dest, alu_fn(m[sel].op, m[sel].vj, m[sel].vk), cyc + 2});
            nm[sel].valid = 1'b0;
         end else begin
            m_alu_cal = 1'b0;
         end
         if (issue_valid && al >= 0) begin
            nm[al] = '{1'b1, issue_op, issue_vj, issue_qj_valid, issue_qj,
                       issue_vk, issue_qk_valid, issue_qk, issue_dest};
            wake_op(nm[al].qjv, nm[al].qj, nm[al].vj);
            wake_op(nm[al].qkv, nm[al].qk, nm[al].vk);
         end
         if (pq.size() > 0 && pq[0].due == cyc) begin
            m_out_valid = 1'b1; m_out_tag = pq[0].tag; m_out_value = pq[0].val;
            void'(pq.pop_front());
         end else begin
            m_out_valid = 1'b0;
         end
      end
      m = nm;
      m_full = 1'b1;
      for (int i = 0; i < RS; i++) if (!m[i].valid) m_full = 1'b0;
      cyc++;
   endtask

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      check("full", 32'(full), 32'(m_full));
      check("alu_cal", 32'(alu_cal), 32'(m_alu_cal));
      check("alu_a", alu_a, m_alu_a);
      check("alu_b", alu_b, m_alu_b);
      check("alu_op", 32'(alu_op), 32'(m_alu_op));
      check("out_valid", 32'(out_valid), 32'(m_out_valid));
      if (m_out_valid) begin
         check("out_tag", 32'(out_tag), 32'(m_out_tag));
         check("out_value", out_value, m_out_value);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      model_step();
      #1;
      check_all();
      issue_valid = 1'b0;
      cdb_valid   = 1'b0;
      clear       = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic issue(input logic [3:0] op, input logic [31:0] vj, input logic qjv,
                        input logic [3:0] qj, input logic [31:0] vk, input logic qkv,
                        input logic [3:0] qk, input logic [3:0] dest);
      issue_valid = 1'b1; issue_op = op;
      issue_vj = vj; issue_qj_valid = qjv; issue_qj = qj;
      issue_vk = vk; issue_qk_valid = qkv; issue_qk = qk;
      issue_dest = dest;
   endtask

   task automatic cdb(input logic [3:0] tag, input logic [31:0] val);
      cdb_valid = 1'b1; cdb_tag = tag; cdb_value = val;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] bseq [8];
      int          ov_seen;

      rst_in = 1'b0; rdy_in = 1'b1; clear = 1'b0;
      issue_valid = 1'b0; issue_op = 4'd0; issue_vj = 32'd0; issue_qj_valid = 1'b0;
      issue_qj = 4'd0; issue_vk = 32'd0; issue_qk_valid = 1'b0; issue_qk = 4'd0;
      issue_dest = 4'd0; cdb_valid = 1'b0; cdb_tag = 4'd0; cdb_value = 32'd0;
      model_reset();

      // Reset state
      #12;
      check_all();
      check("rst_out_tag", 32'(out_tag), 32'd0);
      check("rst_out_value", out_value, 32'd0);
      @(negedge clk_in);
      rst_in = 1'b1;
      idle(2);

      // 1: ready ADD 5+7 -> dest 3
      issue(4'd0, 32'd5, 1'b0, 4'd0, 32'd7, 1'b0, 4'd0, 4'd3); tick();
      tick();
      check("t1_cal", 32'(alu_cal), 32'd1);
      check("t1_a", alu_a, 32'd5);
      check("t1_b", alu_b, 32'd7);
      tick(); tick();
      check("t1_ov", 32'(out_valid), 32'd1);
      check("t1_tag", 32'(out_tag), 32'd3);
      check("t1_val", out_value, 32'd12);
      idle(4);

      // 2: operand A waits on tag 2, woken by the CDB; then same-cycle capture
      issue(4'd0, 32'd0, 1'b1, 4'd2, 32'd1, 1'b0, 4'd0, 4'd4); tick();
      tick();
      check("t2_wait", 32'(alu_cal), 32'd0);
      cdb(4'd2, 32'd10); tick();
      tick();
      check("t2_cal", 32'(alu_cal), 32'd1);
      check("t2_a", alu_a, 32'd10);
      idle(5);
      issue(4'd0, 32'd0, 1'b1, 4'd2, 32'd2, 1'b0, 4'd0, 4'd5);
      cdb(4'd2, 32'd10); tick();
      tick();
      check("t2s_cal", 32'(alu_cal), 32'd1);
      check("t2s_a", alu_a, 32'd10);
      idle(5);

      // 3: B depends on A through the result broadcast
      issue(4'd0, 32'd3, 1'b0, 4'd0, 32'd4, 1'b0, 4'd0, 4'd1); tick();
      issue(4'd0, 32'd100, 1'b0, 4'd0, 32'd0, 1'b1, 4'd1, 4'd2); tick();
      tick(); tick();
      check("t3_a_tag", 32'(out_tag), 32'd1);
      check("t3_a_val", out_value, 32'd7);
      tick();
      check("t3_nobypass", 32'(alu_cal), 32'd0);
      tick();
      check("t3_b_cal", 32'(alu_cal), 32'd1);
      check("t3_b_opb", alu_b, 32'd7);
      tick(); tick();
      check("t3_b_tag", 32'(out_tag), 32'd2);
      check("t3_b_val", out_value, 32'd107);
      idle(4);

      // 4: fill all entries, overflow issue ignored, freed slot 5 reused
      for (int i = 0; i < RS; i++) begin
         issue(4'd0, 32'd0, 1'b1, (i == 5) ? 4'd10 : 4'd9, 32'(i), 1'b0, 4'd0, 4'(i));
         tick();
      end
      check("t4_full", 32'(full), 32'd1);
      issue(4'd0, 32'd1, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 4'd15); tick();
      check("t4_full_hold", 32'(full), 32'd1);
      tick();
      check("t4_ignored", 32'(alu_cal), 32'd0);
      cdb(4'd10, 32'd55); tick();
      tick();
      check("t4_cal5", 32'(alu_cal), 32'd1);
      check("t4_a5", alu_a, 32'd55);
      check("t4_full_drop", 32'(full), 32'd0);
      issue(4'd0, 32'd0, 1'b1, 4'd9, 32'h5A5, 1'b0, 4'd0, 4'd14); tick();
      check("t4_refull", 32'(full), 32'd1);
      cdb(4'd9, 32'd77); tick();
      for (int i = 0; i < 8; i++) begin
         tick();
         bseq[i] = alu_b;
      end
      check("t4_slot5_order", bseq[5], 32'h5A5);
      check("t4_slot4_order", bseq[4], 32'd4);
      idle(4);

      // 5: flush with an op in the ALU and two ready entries
      for (int i = 0; i < 3; i++) begin
         issue(4'd0, 32'd0, 1'b1, 4'd6, 32'd1, 1'b0, 4'd0, 4'(11 + i)); tick();
      end
      cdb(4'd6, 32'd1); tick();
      tick();
      check("t5_inflight", 32'(alu_cal), 32'd1);
      clear = 1'b1;
      issue(4'd0, 32'd9, 1'b0, 4'd0, 32'd9, 1'b0, 4'd0, 4'd8); tick();
      ov_seen = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (out_valid) ov_seen++;
      end
      check("t5_no_out", 32'(ov_seen), 32'd0);
      check("t5_empty", 32'(full), 32'd0);
      issue(4'd1, 32'd20, 1'b0, 4'd0, 32'd8, 1'b0, 4'd0, 4'd7); tick();
      tick(); tick(); tick();
      check("t5_ov", 32'(out_valid), 32'd1);
      check("t5_tag", 32'(out_tag), 32'd7);
      check("t5_val", out_value, 32'd12);
      idle(4);

      // 6: freeze with ready entries, then asynchronous reset mid-stream
      issue(4'd2, 32'd0, 1'b1, 4'd8, 32'hFF, 1'b0, 4'd0, 4'd1); tick();
      issue(4'd3, 32'd0, 1'b1, 4'd8, 32'h10, 1'b0, 4'd0, 4'd2); tick();
      cdb(4'd8, 32'd3); tick();
      rdy_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t6_frozen", 32'(alu_cal), 32'd0);
      end
      rdy_in = 1'b1;
      tick();
      check("t6_resume", 32'(alu_cal), 32'd1);
      check("t6_resume_a", alu_a, 32'd3);
      #2 rst_in = 1'b0;
      #1;
      model_reset();
      check_all();
      check("t6_rst_cal", 32'(alu_cal), 32'd0);
      check("t6_rst_a", alu_a, 32'd0);
      @(negedge clk_in);
      rst_in = 1'b1;
      idle(2);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         issue_valid    = ($urandom_range(0, 9) < 6);
         issue_op       = 4'($urandom_range(0, 5));
         issue_vj       = $urandom;
         issue_qj_valid = ($urandom_range(0, 2) == 0);
         issue_qj       = 4'($urandom);
         issue_vk       = $urandom;
         issue_qk_valid = ($urandom_range(0, 3) == 0);
         issue_qk       = 4'($urandom);
         issue_dest     = 4'($urandom);
         cdb_valid      = ($urandom_range(0, 2) == 0);
         cdb_tag        = 4'($urandom);
         cdb_value      = $urandom;
         clear          = ($urandom_range(0, 59) == 0);
         tick();
      end
      idle(6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
